vrf_writeback_arbiter: RTL and testbench

- Sole driver of the vector register file write port (we3/a3/wd3); merges two result producers into that single port.
- ALU results arrive once per cycle, fixed-latency, and normally have priority.
- Vector load returns arrive via a valid/ready handshake and are buffered in a small FIFO.
- A starvation counter forces a load writeback when loads wait too long; the displaced ALU result is held in a one-entry skid register.

---
 rtl/vrf_wb_if.sv | 29 ++
 rtl/vrf_writeback_arbiter.sv | 112 +++++++++++
 tb/tb_vrf_writeback_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vrf_wb_if.sv
// Writeback bundle between the ALU/load producers, the arbiter and the
// vector register file write port.
interface vrf_wb_if #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ADDR_W = 5
);
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_stall;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              we3;
  logic [ADDR_W-1:0] a3;
  logic [DATA_W-1:0] wd3;
  logic              load_pending;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  alu_stall, mem_ready, we3, a3, wd3, load_pending
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_stall, mem_ready, we3, a3, wd3, load_pending
  );
endinterface

// File: rtl/vrf_writeback_arbiter.sv
// Merges ALU results and buffered load returns onto the single VRF write port,
// with a starvation counter that forces loads and a one-entry ALU skid.
module vrf_writeback_arbiter #(
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_WAIT   = 3
) (
  input logic     clk,
  input logic     rst_n,
  vrf_wb_if.slave wb
);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {ARB_PASS, ARB_HOLD} arb_state_t;

  arb_state_t        state, state_nxt;
  logic [ADDR_W-1:0] fifo_rd   [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr, rptr;
  logic [CNT_W-1:0]  count;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [ADDR_W-1:0] skid_rd;
  logic [DATA_W-1:0] skid_data;
  logic              full, empty, push, pop, forced, skid_load, wr_en;
  logic [ADDR_W-1:0] wr_rd;
  logic [DATA_W-1:0] wr_data;

  assign full   = (count == CNT_W'(FIFO_DEPTH));
  assign empty  = (count == '0);
  // Ready is gated by reset so the producer sees back-pressure immediately.
  assign wb.mem_ready    = rst_n & ~full;
  assign push            = wb.mem_valid & wb.mem_ready;
  assign forced          = (wait_cnt == WAIT_W'(MAX_WAIT)) & ~empty;
  assign wb.alu_stall    = (state == ARB_HOLD);
  assign wb.load_pending = ~empty;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    skid_load = 1'b0;
    wr_en     = 1'b0;
    wr_rd     = fifo_rd[rptr];
    wr_data   = fifo_data[rptr];
    if (forced) begin
      pop   = 1'b1;
      wr_en = 1'b1;
      if (state == ARB_PASS && wb.alu_valid) begin
        skid_load = 1'b1;
        state_nxt = ARB_HOLD;
      end
    end else if (state == ARB_HOLD) begin
      // Live ALU inputs are ignored while the displaced result drains.
      wr_en     = 1'b1;
      wr_rd     = skid_rd;
      wr_data   = skid_data;
      state_nxt = ARB_PASS;
    end else if (wb.alu_valid) begin
      wr_en   = 1'b1;
      wr_rd   = wb.alu_rd;
      wr_data = wb.alu_data;
    end else if (!empty) begin
      pop   = 1'b1;
      wr_en = 1'b1;
    end
  end

  always_comb begin
    wait_nxt = '0;
    if (!empty && !pop) begin
      wait_nxt = (wait_cnt == WAIT_W'(MAX_WAIT)) ? wait_cnt : wait_cnt + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_PASS;
      wait_cnt <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      wb.we3   <= 1'b0;
      wb.a3    <= '0;
      wb.wd3   <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      wb.we3 <= wr_en;
      if (wr_en) begin
        wb.a3  <= wr_rd;
        wb.wd3 <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wptr]   <= wb.mem_rd;
      fifo_data[wptr] <= wb.mem_data;
    end
    if (skid_load) begin
      skid_rd   <= wb.alu_rd;
      skid_data <= wb.alu_data;
    end
  end
endmodule

// File: tb/tb_vrf_writeback_arbiter.sv
// Randomized bench for vrf_writeback_arbiter against a queue-based reference
// model of the writeback arbitration rules.
module tb_vrf_writeback_arbiter;
  localparam int unsigned DW    = 128;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXW  = 3;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vrf_wb_if #(.DATA_W(DW), .ADDR_W(AW)) wb ();

  vrf_writeback_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .MAX_WAIT(MAXW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wb(wb)
  );

  int unsigned n_checks = 0;
  int unsigned errors   = 0;

  // reference model state
  wr_t           mq[$];
  int unsigned   m_wait;
  bit            m_skid;
  wr_t           m_skid_e;
  bit            m_pushed;
  bit            e_we3;
  logic [AW-1:0] e_a3;
  logic [DW-1:0] e_wd3;

  logic [AW-1:0] alu_next_rd, mem_next_rd;
  int unsigned   mem_left;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_wait   = 0;
    m_skid   = 0;
    m_pushed = 0;
    e_we3    = 0;
    e_a3     = '0;
    e_wd3    = '0;
  endtask

  // One clock edge of the arbitration rules, applied to the inputs seen this cycle.
  task automatic model_step();
    bit  ne, full, take_load, wr;
    wr_t w;
    ne        = (mq.size() != 0);
    full      = (mq.size() == DEPTH);
    take_load = 0;
    wr        = 0;
    w         = '0;
    if (m_wait == MAXW && ne) begin
      take_load = 1;
      if (!m_skid && wb.alu_valid) begin
        m_skid   = 1;
        m_skid_e = '{rd: wb.alu_rd, data: wb.alu_data};
      end
    end else if (m_skid) begin
      w      = m_skid_e;
      wr     = 1;
      m_skid = 0;
    end else if (wb.alu_valid) begin
      w  = '{rd: wb.alu_rd, data: wb.alu_data};
      wr = 1;
    end else if (ne) begin
      take_load = 1;
    end
    if (take_load) begin
      w  = mq.pop_front();
      wr = 1;
    end
    if (ne && !take_load) m_wait = (m_wait + 1 > MAXW) ? MAXW : m_wait + 1;
    else                  m_wait = 0;
    m_pushed = wb.mem_valid && !full;
    if (m_pushed) mq.push_back('{rd: wb.mem_rd, data: wb.mem_data});
    e_we3 = wr;
    if (wr) begin
      e_a3  = w.rd;
      e_wd3 = w.data;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("we3",          DW'(wb.we3),          DW'(e_we3));
    chk("a3",           DW'(wb.a3),           DW'(e_a3));
    chk("wd3",          wb.wd3,               e_wd3);
    chk("alu_stall",    DW'(wb.alu_stall),    DW'(m_skid));
    chk("mem_ready",    DW'(wb.mem_ready),    DW'(mq.size() < DEPTH));
    chk("load_pending", DW'(wb.load_pending), DW'(mq.size() != 0));
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Producers: ALU holds its result while stalled; loads hold until accepted.
  task automatic run(input int unsigned cycles, input int unsigned alu_pct, input int unsigned mem_pct);
    for (int unsigned c = 0; c < cycles; c++) begin
      if (!m_skid) begin
        if ($urandom_range(99) < alu_pct) begin
          wb.alu_valid = 1'b1;
          wb.alu_rd    = alu_next_rd;
          wb.alu_data  = rnd_data();
          alu_next_rd  = alu_next_rd + 1'b1;
        end else begin
          wb.alu_valid = 1'b0;
        end
      end
      if (!wb.mem_valid || m_pushed) begin
        if (mem_left != 0 && $urandom_range(99) < mem_pct) begin
          wb.mem_valid = 1'b1;
          wb.mem_rd    = mem_next_rd;
          wb.mem_data  = rnd_data();
          mem_next_rd  = mem_next_rd + 1'b1;
          mem_left--;
        end else begin
          wb.mem_valid = 1'b0;
        end
      end
      tick();
    end
  endtask

  task automatic idle_inputs();
    wb.alu_valid = 1'b0;
    wb.alu_rd    = '0;
    wb.alu_data  = '0;
    wb.mem_valid = 1'b0;
    wb.mem_rd    = '0;
    wb.mem_data  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] d1, d2;
    d1 = 128'h0ABCDE12_3ABCDE12_3ABCDE12_3ABCDE12;
    d2 = 128'h12345678_12345678_12345678_12345678;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_we3",       DW'(wb.we3), '0);
    chk("rst_a3",        DW'(wb.a3), '0);
    chk("rst_wd3",       wb.wd3, '0);
    chk("rst_alu_stall", DW'(wb.alu_stall), '0);
    chk("rst_mem_ready", DW'(wb.mem_ready), '0);
    chk("rst_pending",   DW'(wb.load_pending), '0);
    rst_n = 1'b1;
    #1;
    chk("rel_mem_ready", DW'(wb.mem_ready), DW'(1));

    // 1: single ALU write
    wb.alu_valid = 1'b1; wb.alu_rd = 5'd5; wb.alu_data = d1;
    tick();
    chk("t1_we3", DW'(wb.we3), DW'(1));
    chk("t1_a3",  DW'(wb.a3), DW'(5));
    chk("t1_wd3", wb.wd3, d1);
    wb.alu_valid = 1'b0;
    tick();
    chk("t1_we3_off", DW'(wb.we3), '0);

    // 2: single load, two edges to the write port
    wb.mem_valid = 1'b1; wb.mem_rd = 5'd7; wb.mem_data = d2;
    tick();
    chk("t2_we3_push", DW'(wb.we3), '0);
    chk("t2_pending1", DW'(wb.load_pending), DW'(1));
    wb.mem_valid = 1'b0;
    tick();
    chk("t2_we3", DW'(wb.we3), DW'(1));
    chk("t2_a3",  DW'(wb.a3), DW'(7));
    chk("t2_wd3", wb.wd3, d2);
    chk("t2_pending0", DW'(wb.load_pending), '0);
    m_pushed = 0;

    // 3: four loads against a continuously valid ALU
    alu_next_rd = 5'd10; mem_next_rd = 5'd1; mem_left = 4;
    run(16, 100, 100);
    run(8, 0, 0);

    // 4: fifth load offered while full and popping
    alu_next_rd = 5'd10; mem_next_rd = 5'd1; mem_left = 5;
    run(20, 100, 100);
    run(8, 0, 0);

    // 5: six loads with back-pressure
    alu_next_rd = 5'd16; mem_next_rd = 5'd0; mem_left = 6;
    run(30, 100, 100);
    run(8, 0, 0);

    // 6: reset while loads are queued
    alu_next_rd = 5'd20; mem_next_rd = 5'd1; mem_left = 3;
    run(3, 100, 100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_we3",       DW'(wb.we3), '0);
    chk("t6_mem_ready", DW'(wb.mem_ready), '0);
    chk("t6_pending",   DW'(wb.load_pending), '0);
    chk("t6_alu_stall", DW'(wb.alu_stall), '0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    #1;
    chk("t6_rel_ready", DW'(wb.mem_ready), DW'(1));
    run(6, 0, 0);

    // random traffic
    mem_left = 100000;
    run(500, 60, 50);
    run(200, 90, 90);
    run(200, 20, 30);
    mem_left = 0;
    run(12, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end
endmodule
